// File: rtl/mem_access_ctrl.sv
// Unified-memory initiator: alternates instruction fetch and load/store over one byte-memory port.
// Optional MEM_PERF_CNT_EN adds fetch/load/store/error event counters.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter logic [31:0] NOP    = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        d_err,
   output logic        mem_tick_tock,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_half,
   output logic        mem_byte,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0] cnt_fetch,
   output logic [31:0] cnt_load,
   output logic [31:0] cnt_store,
   output logic [31:0] cnt_err
`endif
);

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic        fetch_fire_c;
   logic        data_fire_c;
   logic        misalign_c;
   logic        oor_c;
   logic        legal_c;
   logic [31:0] ext_data_c;

   // Legality of the pending data request
   always_comb begin
      misalign_c = ((d_size == 2'b01) && d_addr[0]) ||
                   (d_size[1] && (d_addr[1:0] != 2'b00));
      oor_c      = (d_addr >> ADDR_W) != 32'd0;
      legal_c    = !misalign_c && !oor_c;
   end

   // Load data extension; memory returns half/byte zero-extended
   always_comb begin
      case (d_size)
         2'b00:   ext_data_c = d_unsigned ? {24'd0, mem_rdata[7:0]}
                                          : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         2'b01:   ext_data_c = d_unsigned ? {16'd0, mem_rdata[15:0]}
                                          : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         default: ext_data_c = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   // Next state and memory-port decode
   always_comb begin
      state_nxt     = state;
      fetch_fire_c  = 1'b0;
      data_fire_c   = 1'b0;
      d_req_ready   = 1'b0;
      mem_tick_tock = 1'b0;
      mem_addr      = if_addr;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_half      = 1'b0;
      mem_byte      = 1'b0;
      mem_wdata     = 32'd0;
      case (state)
         FETCH: begin
            fetch_fire_c = if_req && !(if_valid && !if_ready);
            state_nxt    = d_req_valid ? DATA : FETCH;
         end
         DATA: begin
            mem_tick_tock = 1'b1;
            d_req_ready   = 1'b1;
            mem_addr      = d_addr;
            mem_wdata     = d_wdata;
            data_fire_c   = d_req_valid;
            if (d_req_valid && legal_c) begin
               mem_read  = !d_we;
               mem_write = d_we;
               mem_half  = (d_size == 2'b01);
               mem_byte  = (d_size == 2'b00);
            end
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Fetch holding register and one-cycle data response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid    <= 1'b0;
         if_instr    <= NOP;
         d_rsp_valid <= 1'b0;
         d_rsp_data  <= 32'd0;
         d_err       <= 1'b0;
      end else begin
         if (fetch_fire_c) begin
            if_instr <= mem_rdata;
            if_valid <= 1'b1;
         end else if (if_ready) begin
            if_valid <= 1'b0;
         end
         d_rsp_valid <= data_fire_c;
         d_err       <= data_fire_c && !legal_c;
         d_rsp_data  <= (data_fire_c && legal_c && !d_we) ? ext_data_c : 32'd0;
      end
   end

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_fetch <= 32'd0;
         cnt_load  <= 32'd0;
         cnt_store <= 32'd0;
         cnt_err   <= 32'd0;
      end else begin
         if (fetch_fire_c)                     cnt_fetch <= cnt_fetch + 32'd1;
         if (data_fire_c && legal_c && !d_we)  cnt_load  <= cnt_load + 32'd1;
         if (data_fire_c && legal_c && d_we)   cnt_store <= cnt_store + 32'd1;
         if (data_fire_c && !legal_c)          cnt_err   <= cnt_err + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-memory model, transaction-level reference memory, random + directed traffic.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_valid, if_ready;
   logic [31:0] if_addr, if_instr;
   logic        d_req_valid, d_req_ready, d_we, d_unsigned;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata, d_rsp_data;
   logic        d_rsp_valid, d_err;
   logic        mem_tick_tock, mem_read, mem_write, mem_half, mem_byte;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   logic [7:0]  ma;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_size(d_size),
      .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_err(d_err),
      .mem_tick_tock(mem_tick_tock), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Combinational-read byte memory, zero-extending half/byte reads
   always_comb begin
      ma = mem_addr[7:0];
      if (mem_byte)      mem_rdata = {24'd0, mem[ma]};
      else if (mem_half) mem_rdata = {16'd0, mem[ma + 8'd1], mem[ma]};
      else               mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
   end

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wdata[7:0];
         if (!mem_byte) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
         if (!mem_byte && !mem_half) begin
            mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] addr);
      logic [31:0] v = 0;
      for (int i = 0; i < 4; i++) v = v + (32'(ref_mem[addr[7:0] + 8'(i)]) << (8 * i));
      return v;
   endfunction

   function automatic bit ref_is_err(input logic [1:0] size, input logic [31:0] addr);
      if (addr >= 32'd256) return 1'b1;
      if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
      if (size >= 2'd2 && (addr % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns, input logic [31:0] addr);
      logic [31:0] v;
      if (size == 2'd0) begin
         v = 32'(ref_mem[addr[7:0]]);
         if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (size == 2'd1) begin
         v = 32'(ref_mem[addr[7:0]]) + 32'(ref_mem[addr[7:0] + 8'd1]) * 32'd256;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else begin
         v = ref_word(addr);
      end
      return v;
   endfunction

   task automatic fetch_txn(input logic [31:0] addr);
      if_req = 1'b1; if_addr = addr; if_ready = 1'b1; d_req_valid = 1'b0;
      #1;
      check("fetch_phase", {31'd0, mem_tick_tock}, 32'd0);
      check("fetch_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0;
      check("if_valid", {31'd0, if_valid}, 32'd1);
      check("if_instr", if_instr, ref_word(addr));
   endtask

   task automatic data_txn(input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
      int  waits = 0;
      bit  err   = ref_is_err(size, addr);
      logic [31:0] exp = (err || we) ? 32'd0 : ref_load(size, uns, addr);
      if_req = 1'b0; if_ready = 1'b1;
      d_req_valid = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
      #1;
      while (!d_req_ready && waits < 4) begin @(posedge clk); #2; waits++; end
      check("d_req_ready", {31'd0, d_req_ready}, 32'd1);
      check("data_phase", {31'd0, mem_tick_tock}, 32'd1);
      check("mem_read", {31'd0, mem_read}, {31'd0, !err && !we});
      check("mem_write", {31'd0, mem_write}, {31'd0, !err && we});
      @(posedge clk); #1;
      d_req_valid = 1'b0;
      check("rsp_valid", {31'd0, d_rsp_valid}, 32'd1);
      check("rsp_err", {31'd0, d_err}, {31'd0, err});
      check("rsp_data", d_rsp_data, exp);
      check("wr_drop", {31'd0, mem_write}, 32'd0);
      if (we && !err) begin
         int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
         for (int i = 0; i < n; i++) ref_mem[addr[7:0] + 8'(i)] = 8'(wdata >> (8 * i));
      end
   endtask

   initial begin
      int nf, nd, waits;
      logic [7:0] pre [8] = '{8'hFF, 8'h54, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h82};
      for (int i = 0; i < 256; i++) begin
         mem[i] = (i < 8) ? pre[i] : 8'h00;
         ref_mem[i] = mem[i];
      end
      rst_n = 1'b0; if_req = 0; if_addr = 0; if_ready = 0; d_req_valid = 0;
      d_we = 0; d_size = 0; d_unsigned = 0; d_addr = 0; d_wdata = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'h00000013);
      check("rst_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
      check("rst_rsp_data", d_rsp_data, 32'd0);
      check("rst_err", {31'd0, d_err}, 32'd0);
      check("rst_phase", {31'd0, mem_tick_tock}, 32'd0);
      @(posedge clk); #1;

      fetch_txn(32'd0);
      check("fetch0_const", if_instr, 32'h020154FF);
      data_txn(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      check("lb_signed", d_rsp_data, 32'hFFFFFFFF);
      data_txn(1'b0, 2'd0, 1'b1, 32'd0, 32'd0);
      check("lbu", d_rsp_data, 32'h000000FF);
      data_txn(1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
      check("lh_signed", d_rsp_data, 32'hFFFF8210);
      data_txn(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF);
      data_txn(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
      check("sw_lw", d_rsp_data, 32'hDEADBEEF);
      data_txn(1'b0, 2'd2, 1'b0, 32'd2, 32'd0);
      data_txn(1'b0, 2'd1, 1'b0, 32'd1, 32'd0);
      data_txn(1'b0, 2'd0, 1'b0, 32'h100, 32'd0);
      data_txn(1'b1, 2'd3, 1'b0, 32'd16, 32'hCAFEF00D);

      // Concurrent fetch and data traffic must alternate phases
      if_req = 1'b1; if_addr = 32'd4; if_ready = 1'b1;
      d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'd4;
      nf = 0; nd = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("alt_phase", {31'd0, mem_tick_tock}, 32'(i % 2));
         @(posedge clk); #1;
         if (if_valid) begin nf++; check("alt_instr", if_instr, ref_word(32'd4)); end
         if (d_rsp_valid) begin nd++; check("alt_data", d_rsp_data, ref_word(32'd4)); end
      end
      if_req = 1'b0; d_req_valid = 1'b0;
      check("alt_fetches", 32'(nf), 32'd5);
      check("alt_rsps", 32'(nd), 32'd5);
      @(posedge clk); #1;

      // Reset while a store is on the port
      d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'd12; d_wdata = 32'h11223344;
      #1;
      waits = 0;
      while (!d_req_ready && waits < 4) begin @(posedge clk); #2; waits++; end
      check("rst_st_write", {31'd0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_st_drop", {31'd0, mem_write}, 32'd0);
      check("rst_st_phase", {31'd0, mem_tick_tock}, 32'd0);
      check("rst_st_ifv", {31'd0, if_valid}, 32'd0);
      check("rst_st_nop", if_instr, 32'h00000013);
      d_req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_st_rsp", {31'd0, d_rsp_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      data_txn(1'b0, 2'd2, 1'b0, 32'd12, 32'd0);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            fetch_txn({24'd0, 6'($urandom_range(0, 63)), 2'b00});
         end else begin
            logic [31:0] a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | (32'h100 << $urandom_range(0, 20));
            data_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
